// File: rtl/encoder_counter.sv
// encoder_counter: position / velocity accumulator fed by a 4x quadrature decoder.
// It keeps a wrapping signed position, latches the position on every index rising
// edge, runs a homing state machine and emits a windowed velocity sample.
//
// Handshake: vel_valid is a one-cycle strobe and velocity is held stable until the
// next strobe. There is no back-pressure, so the consumer must take the value on
// the strobe cycle or read the held velocity later.
module encoder_counter #(
  parameter int POS_WIDTH  = 32,
  parameter int VEL_WIDTH  = 16,
  parameter int VEL_PERIOD = 1000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 count_pulse,
  input  logic                 direction,
  input  logic                 index,
  input  logic                 enable,
  input  logic                 pos_load,
  input  logic [POS_WIDTH-1:0] load_value,
  input  logic                 home_arm,
  output logic [POS_WIDTH-1:0] position,
  output logic [POS_WIDTH-1:0] index_pos,
  output logic                 homed,
  output logic [VEL_WIDTH-1:0] velocity,
  output logic                 vel_valid,
  output logic [1:0]           state_dbg
);

  localparam int TW     = (VEL_PERIOD > 1) ? $clog2(VEL_PERIOD) : 1;
  localparam int VMAX_I = (1 << (VEL_WIDTH - 1)) - 1;

  localparam logic [TW-1:0]               TIMER_LAST = TW'(VEL_PERIOD - 1);
  localparam logic signed [VEL_WIDTH:0]   SAT_HI     = (VEL_WIDTH + 1)'(VMAX_I);
  localparam logic signed [VEL_WIDTH:0]   SAT_LO     = -SAT_HI;
  localparam logic [VEL_WIDTH-1:0]        SAT_HI_N   = VEL_WIDTH'(VMAX_I);
  localparam logic [VEL_WIDTH-1:0]        SAT_LO_N   = -SAT_HI_N;

  typedef enum logic [1:0] {
    ST_UNHOMED = 2'd0,
    ST_ARMED   = 2'd1,
    ST_HOMED   = 2'd2
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic                   idx_q;
  logic                   rise;
  logic                   step;
  logic                   home_clear;
  logic [POS_WIDTH-1:0]   pos_delta;
  logic [TW-1:0]          timer;
  logic                   window_end;
  logic [VEL_WIDTH-1:0]   acc;
  logic signed [VEL_WIDTH:0] vel_delta;
  logic signed [VEL_WIDTH:0] acc_sum;
  logic [VEL_WIDTH-1:0]   acc_sat;

  assign step       = count_pulse & enable;
  assign rise       = index & ~idx_q;
  assign home_clear = (state == ST_ARMED) & rise;
  assign pos_delta  = direction ? POS_WIDTH'(1) : {POS_WIDTH{1'b1}};
  assign window_end = (timer == TIMER_LAST);

  // Signed step delta and saturating accumulate; one guard bit catches overflow.
  always_comb begin
    vel_delta = '0;
    if (step) begin
      vel_delta = direction ? (VEL_WIDTH + 1)'(1) : {(VEL_WIDTH + 1){1'b1}};
    end
    acc_sum = $signed({acc[VEL_WIDTH-1], acc}) + vel_delta;
    if (acc_sum > SAT_HI) begin
      acc_sat = SAT_HI_N;
    end else if (acc_sum < SAT_LO) begin
      acc_sat = SAT_LO_N;
    end else begin
      acc_sat = acc_sum[VEL_WIDTH-1:0];
    end
  end

  // Previous index level for rising-edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q <= 1'b0;
    end else begin
      idx_q <= index;
    end
  end

  // Latch the pre-update position on every index rise, whatever else happens.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      index_pos <= '0;
    end else if (rise) begin
      index_pos <= position;
    end
  end

  // Position: load beats homing clear, which beats a count step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      position <= '0;
    end else if (pos_load) begin
      position <= load_value;
    end else if (home_clear) begin
      position <= '0;
    end else if (step) begin
      position <= position + pos_delta;
    end
  end

  // Homing FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_UNHOMED;
    end else begin
      state <= state_nxt;
    end
  end

  // Homing FSM next state; a rise coinciding with arming in UNHOMED only arms.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_UNHOMED: if (home_arm) state_nxt = ST_ARMED;
      ST_ARMED:   if (rise)     state_nxt = ST_HOMED;
      ST_HOMED:   if (home_arm) state_nxt = ST_ARMED;
      default:                  state_nxt = ST_UNHOMED;
    endcase
  end

  // Homing FSM outputs, decoded from the registered state.
  always_comb begin
    homed     = (state == ST_HOMED);
    state_dbg = state;
  end

  // Free-running velocity window timer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer <= '0;
    end else if (window_end) begin
      timer <= '0;
    end else begin
      timer <= timer + TW'(1);
    end
  end

  // Window accumulator; counts every valid step, even ones position discards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
    end else if (window_end) begin
      acc <= '0;
    end else begin
      acc <= acc_sat;
    end
  end

  // Publish the closing window's total, including the last cycle's step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      velocity  <= '0;
      vel_valid <= 1'b0;
    end else begin
      vel_valid <= window_end;
      if (window_end) begin
        velocity <= acc_sat;
      end
    end
  end

endmodule

// File: doc/encoder_counter.md
Name: encoder_counter

Overview:
- Position/velocity accumulator that sits directly downstream of the 4x quadrature decoder.
- Consumes its per-edge count_pulse, direction and synchronized index outputs.
- Maintains a wrapping signed position count, captures position on each index edge, and runs a homing state machine.
- Produces a windowed velocity sample for the motion-control register bank.

Parameters:
- POS_WIDTH, 32, width of position, load_value and index_pos.
- VEL_WIDTH, 16, width of signed velocity sample.
- VEL_PERIOD, 1000, clock cycles per velocity window (>= 2).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- count_pulse  input  1  one-cycle count strobe from decoder, already synchronous to clk.
- direction  input  1  1 = increment, 0 = decrement; qualified by count_pulse.
- index  input  1  synchronized index level from decoder.
- enable  input  1  1 = accept count pulses; 0 = ignore them.
- pos_load  input  1  one-cycle strobe: load position from load_value.
- load_value  input  POS_WIDTH  preset value for pos_load.
- home_arm  input  1  one-cycle strobe: arm homing on next index rising edge.
- position  output  POS_WIDTH  current position, two's complement.
- index_pos  output  POS_WIDTH  position captured at last index rising edge.
- homed  output  1  1 while in HOMED state.
- velocity  output  VEL_WIDTH  signed net pulses counted in last completed window.
- vel_valid  output  1  one-cycle strobe when velocity updates.

Behaviour:
- Reset values (asserted asynchronously, held while reset=1):
  - position = 0, index_pos = 0, homed = 0, velocity = 0, vel_valid = 0.
  - Homing FSM = UNHOMED, window timer = 0, velocity accumulator = 0, index edge register = 0.
- Valid step: step = count_pulse & enable. Delta is +1 if direction=1, -1 if direction=0.
- Position update priority, registered, 1-cycle latency from input to position:
  1. pos_load=1: position <= load_value; step discarded.
  2. Index rising edge while ARMED: position <= 0; step discarded.
  3. Step: position <= position + delta, modulo 2^POS_WIDTH. 0x7FFFFFFF+1 -> 0x80000000; 0-1 -> 0xFFFFFFFF.
- Index edge detection:
  - idx_q registers index; rise = index & ~idx_q.
  - On rise, index_pos <= the position value before that cycle's update, in every FSM state.
  - Capture occurs even when pos_load is asserted in the same cycle.
- Homing FSM:
  - UNHOMED --home_arm--> ARMED.
  - ARMED --rise--> HOMED; position is cleared in that same cycle.
  - HOMED --home_arm--> ARMED; homed drops on the next cycle.
  - In ARMED, home_arm is ignored.
  - pos_load is accepted in any state and does not change state.
  - homed = (state == HOMED), registered.
  - If home_arm and rise occur in the same cycle while UNHOMED, the FSM goes to ARMED only; the rise is not used for homing.
- Velocity:
  - Window timer counts 0..VEL_PERIOD-1 continuously, independent of enable and pos_load.
  - The signed accumulator adds each valid step's delta, saturating at ±(2^(VEL_WIDTH-1)-1).
  - Steps discarded for position (pos_load, homing clear) are still counted in the accumulator.
  - On the cycle the timer equals VEL_PERIOD-1:
    - velocity <= saturated (acc + this cycle's delta);
    - acc <= 0; timer <= 0; vel_valid = 1 for that one registered cycle.
  - First vel_valid occurs VEL_PERIOD cycles after reset release.
- Reset mid-operation: every register, the FSM and any in-progress window are discarded immediately. No partial velocity is emitted.

Test Plan:
- Directed count: reset, enable=1, 5 pulses direction=1 then 2 pulses direction=0 -> position=3, one cycle after the last pulse.
- Wrap: pos_load with load_value=0xFFFFFFFE, then 3 up pulses -> position=0x00000001. Then load 0, 1 down pulse -> 0xFFFFFFFF.
- Homing: position=100, home_arm, then index rising edge with count_pulse=1 in the same cycle -> index_pos=100, position=0, homed=1 the next cycle. A second index edge -> position unaffected, index_pos updated.
- Priority: pos_load=1 with load_value=50, same cycle as an ARMED index rise and a pulse -> position=50, state HOMED, index_pos = prior position.
- Velocity (VEL_PERIOD=10, VEL_WIDTH=4): 3 up and 1 down pulse in window -> vel_valid at cycle 10 with velocity=2. Then 9 up pulses with enable=1 -> velocity=7 (saturated). With enable=0 -> velocity=0.
- Async reset: assert reset mid-window while HOMED with position=42 -> all outputs 0 immediately, without a clock edge. After release, the first vel_valid occurs exactly VEL_PERIOD cycles later.
